// File: rtl/rggen_apb_arbiter_pkg.sv
// Shared types and helpers for the APB host arbiter.
// Holds the FSM state encoding and an index-width helper that stays legal for small counts.
package rggen_apb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  // Width of an index able to address n entries; never returns 0.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rggen_apb_if.sv
// APB bus bundle between the arbiter (master) and the register block (slave).
// Handshake: a transfer completes on the clock edge where psel, penable and pready are all high.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      psel;
  logic                      penable;
  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic [2:0]                pprot;
  logic                      pwrite;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_rr_arbiter.sv
// Round-robin grant generator: one-hot grant plus index, pointer advances past the winner on update.
// The pointer holds the first host to consider in the next search.
module rggen_rr_arbiter
  import rggen_apb_arbiter_pkg::*;
#(
  parameter int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_update,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_index
);

  logic [IW-1:0] r_ptr;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_index = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [IW-1:0] w_cand;
      w_cand = IW'((int'(r_ptr) + i) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_index          = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= (o_index == IW'(N - 1)) ? '0 : o_index + 1'b1;
    end
  end

endmodule

// File: rtl/rggen_apb_arbiter.sv
// Shares one APB master port between N_HOSTS req/ack hosts with round-robin arbitration,
// SETUP/ACCESS sequencing and an optional ACCESS-phase watchdog.
module rggen_apb_arbiter
  import rggen_apb_arbiter_pkg::*;
#(
  parameter int         N_HOSTS        = 2,
  parameter int         ADDRESS_WIDTH  = 16,
  parameter int         DATA_WIDTH     = 32,
  parameter logic [2:0] PPROT          = 3'b000,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_HOSTS-1:0]                  i_req,
  input  logic [N_HOSTS*ADDRESS_WIDTH-1:0]    i_address,
  input  logic [N_HOSTS-1:0]                  i_write,
  input  logic [N_HOSTS*DATA_WIDTH-1:0]       i_wdata,
  input  logic [N_HOSTS*DATA_WIDTH/8-1:0]     i_strb,
  output logic [N_HOSTS-1:0]                  o_ack,
  output logic [DATA_WIDTH-1:0]               o_rdata,
  output logic                                o_slverr,
  rggen_apb_if.master                         apb_if
);

  localparam int IW  = idx_width(N_HOSTS);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int WDW = idx_width(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;

  logic [1:0]               r_state;
  logic                     r_psel;
  logic                     r_penable;
  logic                     r_pwrite;
  logic [ADDRESS_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0]    r_pwdata;
  logic [SW-1:0]            r_pstrb;
  logic [N_HOSTS-1:0]       r_grant;
  logic [N_HOSTS-1:0]       r_ack;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_slverr;
  logic [WDW-1:0]           r_wdog;

  logic [N_HOSTS-1:0]       w_eligible;
  logic [N_HOSTS-1:0]       w_grant;
  logic [IW-1:0]            w_index;
  logic                     w_update;
  logic                     w_timeout;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic                     w_sel_write;
  logic [DATA_WIDTH-1:0]    w_sel_wdata;
  logic [SW-1:0]            w_sel_strb;

  // A host whose ack is pulsing this cycle may still hold i_req; it must not win again.
  assign w_eligible = i_req & ~r_ack;
  assign w_update   = (r_state == ST_IDLE) && (|w_eligible);
  assign w_timeout  = (TIMEOUT_CYCLES > 0) && (r_wdog == WD_LAST) && !apb_if.pready;

  rggen_rr_arbiter #(.N(N_HOSTS)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_eligible),
    .i_update (w_update),
    .o_grant  (w_grant),
    .o_index  (w_index)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    w_sel_strb  = '0;
    for (int h = 0; h < N_HOSTS; h++) begin
      if (w_index == IW'(h)) begin
        w_sel_addr  = i_address[h*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        w_sel_write = i_write[h];
        w_sel_wdata = i_wdata[h*DATA_WIDTH +: DATA_WIDTH];
        w_sel_strb  = i_strb[h*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_update) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= w_sel_addr;
            r_pwrite  <= w_sel_write;
            r_pwdata  <= w_sel_wdata;
            r_pstrb   <= w_sel_strb;
            r_grant   <= w_grant;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apb_if.pready || w_timeout) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_ack     <= r_grant;
            r_wdog    <= '0;
            r_state   <= ST_IDLE;
            if (apb_if.pready) begin
              if (!r_pwrite) r_rdata <= apb_if.prdata;
              r_slverr <= apb_if.pslverr;
            end else begin
              r_slverr <= 1'b1;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign apb_if.psel    = r_psel;
  assign apb_if.penable = r_penable;
  assign apb_if.paddr   = r_paddr;
  assign apb_if.pwrite  = r_pwrite;
  assign apb_if.pwdata  = r_pwdata;
  assign apb_if.pstrb   = r_pstrb;
  assign apb_if.pprot   = PPROT;
  assign o_ack          = r_ack;
  assign o_rdata        = r_rdata;
  assign o_slverr       = r_slverr;

endmodule

// File: tb/tb_rggen_apb_arbiter.sv
// Directed bench for rggen_apb_arbiter: four hosts, watchdog of 8 ACCESS cycles,
// a reactive APB slave model and an ack-driven scoreboard.
module tb_rggen_apb_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    i_req;
  logic [N*AW-1:0] i_address;
  logic [N-1:0]    i_write;
  logic [N*DW-1:0] i_wdata;
  logic [N*SW-1:0] i_strb;
  logic [N-1:0]    o_ack;
  logic [DW-1:0]   o_rdata;
  logic            o_slverr;

  rggen_apb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb_bus ();

  rggen_apb_arbiter #(
    .N_HOSTS        (N),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .PPROT          (3'b000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_address (i_address),
    .i_write   (i_write),
    .i_wdata   (i_wdata),
    .i_strb    (i_strb),
    .o_ack     (o_ack),
    .o_rdata   (o_rdata),
    .o_slverr  (o_slverr),
    .apb_if    (apb_bus)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [1:0]    host;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int h, input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.host = 2'(h); e.addr = addr; e.wr = wr; e.wdata = wdata;
    e.strb = strb;  e.rdata = rdata; e.err = err;
    exp_q.push_back(e);
  endtask

  // ---------------- APB slave model ----------------
  int          slv_wait = 0;
  int          slv_cnt  = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  logic        slv_addr_mode = 1'b0;

  initial begin
    apb_bus.pready  = 1'b0;
    apb_bus.prdata  = '0;
    apb_bus.pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (apb_bus.psel && apb_bus.penable) begin
        if (slv_cnt >= slv_wait) begin
          apb_bus.pready  = 1'b1;
          apb_bus.prdata  = slv_addr_mode ? {16'hCAFE, apb_bus.paddr} : slv_rdata;
          apb_bus.pslverr = slv_err;
        end else begin
          apb_bus.pready  = 1'b0;
          apb_bus.pslverr = 1'b0;
          slv_cnt++;
        end
      end else begin
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        slv_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [AW-1:0] cap_addr;
  logic          cap_wr;
  logic [DW-1:0] cap_wdata;
  logic [SW-1:0] cap_strb;

  initial begin
    exp_t e;
    logic [N-1:0] one;
    one = 4'b0001;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (apb_bus.psel && !apb_bus.penable) begin
          cap_addr  = apb_bus.paddr;
          cap_wr    = apb_bus.pwrite;
          cap_wdata = apb_bus.pwdata;
          cap_strb  = apb_bus.pstrb;
        end else if (apb_bus.psel && apb_bus.penable) begin
          chk("paddr stable in ACCESS", 64'(apb_bus.paddr), 64'(cap_addr));
          chk("pwrite/pstrb/pwdata stable in ACCESS",
              64'({apb_bus.pwrite, apb_bus.pstrb, apb_bus.pwdata}),
              64'({cap_wr, cap_strb, cap_wdata}));
        end
        if (o_ack != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected ack", 64'(o_ack), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("ack host", 64'(o_ack), 64'(one << e.host));
            chk("rdata", 64'(o_rdata), 64'(e.rdata));
            chk("slverr", 64'(o_slverr), 64'(e.err));
            chk("paddr of transfer", 64'(cap_addr), 64'(e.addr));
            chk("pwrite/pstrb/pwdata of transfer",
                64'({cap_wr, cap_strb, cap_wdata}), 64'({e.wr, e.strb, e.wdata}));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_xfer(input int h, input logic [AW-1:0] addr, input logic wr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input bit keep);
    int t;
    i_address[h*AW +: AW] = addr;
    i_write[h]            = wr;
    i_wdata[h*DW +: DW]   = wdata;
    i_strb[h*SW +: SW]    = strb;
    i_req[h]              = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!o_ack[h] && t < 300);
    chk($sformatf("ack arrived host%0d", h), 64'(o_ack[h]), 64'(1));
    if (!keep) begin
      @(posedge clk);
      #1;
      i_req[h] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_req = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    bit seen;
    i_req = '0; i_address = '0; i_write = '0; i_wdata = '0; i_strb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset psel", 64'(apb_bus.psel), 64'(0));
    chk("reset penable", 64'(apb_bus.penable), 64'(0));
    chk("reset paddr", 64'(apb_bus.paddr), 64'(0));
    chk("reset pprot", 64'(apb_bus.pprot), 64'(0));
    chk("reset o_ack", 64'(o_ack), 64'(0));
    chk("reset o_rdata", 64'(o_rdata), 64'(0));
    chk("reset o_slverr", 64'(o_slverr), 64'(0));

    // Single write host0, immediate pready: psel c1, penable c2, ack c3
    @(posedge clk);
    #1;
    push_exp(0, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    fork
      host_xfer(0, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
      begin
        @(negedge clk); chk("c0 psel", 64'(apb_bus.psel), 64'(0));
        @(negedge clk); chk("c1 psel/penable", 64'({apb_bus.psel, apb_bus.penable}), 64'(2'b10));
        @(negedge clk); chk("c2 psel/penable", 64'({apb_bus.psel, apb_bus.penable}), 64'(2'b11));
        chk("c2 o_ack", 64'(o_ack), 64'(0));
        @(negedge clk); chk("c3 o_ack", 64'(o_ack), 64'(4'b0001));
        chk("c3 psel", 64'(apb_bus.psel), 64'(0));
      end
    join
    // Host0 held i_req through its ack cycle: it must not be regranted
    @(negedge clk); chk("no regrant after ack", 64'(apb_bus.psel), 64'(0));

    // Read host1 with 3 wait cycles
    slv_wait = 3; slv_rdata = 32'h12345678;
    @(posedge clk);
    #1;
    push_exp(1, 16'h0020, 1'b0, 32'h0, 4'h0, 32'h12345678, 1'b0);
    host_xfer(1, 16'h0020, 1'b0, 32'h0, 4'h0, 1'b0);

    // Round robin after reset, all four hosts requesting: 0,1,2,3,0,1
    do_reset();
    slv_addr_mode = 1'b1; slv_wait = 1;
    push_exp(0, 16'h0100, 1'b1, 32'h00000100, 4'hF, 32'h0, 1'b0);
    push_exp(1, 16'h0104, 1'b0, 32'h0, 4'h0, 32'hCAFE0104, 1'b0);
    push_exp(2, 16'h0108, 1'b1, 32'h00000108, 4'h3, 32'hCAFE0104, 1'b0);
    push_exp(3, 16'h010C, 1'b0, 32'h0, 4'h0, 32'hCAFE010C, 1'b0);
    push_exp(0, 16'h0200, 1'b1, 32'h11110000, 4'hF, 32'hCAFE010C, 1'b0);
    push_exp(1, 16'h0204, 1'b0, 32'h0, 4'h0, 32'hCAFE0204, 1'b0);
    fork
      begin
        host_xfer(0, 16'h0100, 1'b1, 32'h00000100, 4'hF, 1'b1);
        host_xfer(0, 16'h0200, 1'b1, 32'h11110000, 4'hF, 1'b0);
      end
      begin
        host_xfer(1, 16'h0104, 1'b0, 32'h0, 4'h0, 1'b1);
        host_xfer(1, 16'h0204, 1'b0, 32'h0, 4'h0, 1'b0);
      end
      host_xfer(2, 16'h0108, 1'b1, 32'h00000108, 4'h3, 1'b0);
      host_xfer(3, 16'h010C, 1'b0, 32'h0, 4'h0, 1'b0);
    join

    // pslverr on write host2, then clean read host3
    slv_addr_mode = 1'b0; slv_wait = 0; slv_rdata = 32'h55AA55AA; slv_err = 1'b1;
    push_exp(2, 16'h0030, 1'b1, 32'hA5A5A5A5, 4'h5, 32'hCAFE0204, 1'b1);
    host_xfer(2, 16'h0030, 1'b1, 32'hA5A5A5A5, 4'h5, 1'b0);
    slv_err = 1'b0;
    push_exp(3, 16'h0034, 1'b0, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
    host_xfer(3, 16'h0034, 1'b0, 32'h0, 4'h0, 1'b0);

    // Watchdog: slave never ready, 8 ACCESS cycles then error ack
    slv_wait = 1000;
    push_exp(1, 16'h0040, 1'b0, 32'h0, 4'h0, 32'h55AA55AA, 1'b1);
    cnt = 0;
    fork
      host_xfer(1, 16'h0040, 1'b0, 32'h0, 4'h0, 1'b0);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (apb_bus.psel && apb_bus.penable) cnt++;
          else if (cnt > 0) break;
        end
      end
    join
    chk("ACCESS cycles before timeout", 64'(cnt), 64'(8));
    slv_wait = 0;
    push_exp(0, 16'h0044, 1'b1, 32'h00000044, 4'hF, 32'h55AA55AA, 1'b0);
    host_xfer(0, 16'h0044, 1'b1, 32'h00000044, 4'hF, 1'b0);

    // Reset during ACCESS of a host1 read: transfer discarded, host 0 wins first afterwards
    slv_wait = 1000;
    @(posedge clk);
    #1;
    i_address[1*AW +: AW] = 16'h0050;
    i_write[1] = 1'b0;
    i_req[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (apb_bus.psel && apb_bus.penable) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached ACCESS before reset", 64'(apb_bus.penable), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_req = '0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("reset in ACCESS psel", 64'(apb_bus.psel), 64'(0));
    chk("reset in ACCESS penable", 64'(apb_bus.penable), 64'(0));
    chk("reset in ACCESS o_ack", 64'(o_ack), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slv_wait = 0; slv_rdata = 32'h0BADF00D;
    push_exp(0, 16'h0060, 1'b1, 32'h00000060, 4'hF, 32'h0, 1'b0);
    push_exp(2, 16'h0064, 1'b0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
    fork
      host_xfer(0, 16'h0060, 1'b1, 32'h00000060, 4'hF, 1'b0);
      host_xfer(2, 16'h0064, 1'b0, 32'h0, 4'h0, 1'b0);
    join

    repeat (5) @(posedge clk);
    chk("expected queue drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
